// File: rtl/cpu_run_ctrl_pkg.sv
// Purpose: shared types and constants for the rv32i run sequencer.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package cpu_run_ctrl_pkg;

    // Run sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_e;

    // d_mem access size encodings. A mode of 2'b11 is also treated as a word.
    localparam logic [1:0] MODE_B = 2'b00;
    localparam logic [1:0] MODE_H = 2'b01;
    localparam logic [1:0] MODE_W = 2'b10;

    // Byte address of the completion mailbox word.
    localparam int MBOX_ADDR_DEFAULT = 8;

    // Returns the lanes that a store of the given size actually carries.
    // The mailbox value is zero-extended from those lanes.
    function automatic logic [31:0] mode_mask(input logic [1:0] mode);
        case (mode)
            MODE_B:  mode_mask = 32'h0000_00FF;
            MODE_H:  mode_mask = 32'h0000_FFFF;
            default: mode_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_cnt.sv
// Purpose: saturating RUN-cycle counter with a watchdog limit flag (CPU_RUN_CTRL_WATCHDOG_EN).
// Latency: the count updates on the edge after clr/en; limit_hit is combinational from the count.
// Backpressure: none; clr overrides en, and the count holds at all-ones.
module cpu_run_ctrl_cnt #(
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             limit_hit
);

    // Count enabled cycles and saturate so that a stuck run never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    // The last permitted RUN cycle is the one where the count reads MAX_CYCLES-1.
    assign limit_hit = (cnt == CNT_W'(MAX_CYCLES - 1));
`else
    // Without a watchdog, a run can only end on a mailbox store.
    assign limit_hit = 1'b0;
    logic unused_limit;
    assign unused_limit = ^MAX_CYCLES;
`endif

endmodule

// File: rtl/cpu_run_ctrl.sv
// Purpose: holds rv32i in reset while the host owns d_mem, runs the CPU until a mailbox store or watchdog (CPU_RUN_CTRL_WATCHDOG_EN).
// Latency: a start sampled at edge N releases the CPU from N+1; a mailbox hit sampled at edge M freezes it from M+1.
// Backpressure: none; start is ignored in RUN, clear is ignored in IDLE/RUN, and start wins over clear.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_W     = 32,
    parameter int MBOX_ADDR  = MBOX_ADDR_DEFAULT,
    parameter int MAX_CYCLES = 200,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    // host/bench memory port
    input  logic                  host_we,
    input  logic [1:0]            host_mode,
    input  logic [ADDR_WIDTH-1:0] host_waddr,
    input  logic [ADDR_WIDTH-1:0] host_raddr,
    input  logic [DATA_W-1:0]     host_wdata,
    output logic [DATA_W-1:0]     host_rdata,
    // rv32i memory port
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_mode,
    input  logic [ADDR_WIDTH-1:0] cpu_waddr,
    input  logic [ADDR_WIDTH-1:0] cpu_raddr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_n_rst,
    // d_mem port
    output logic                  mem_we,
    output logic [1:0]            mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    // status
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  host_err,
    output logic [DATA_W-1:0]     result,
    output logic [CNT_W-1:0]      cycles
);

    localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN     = 2'(ST_RUN);
    localparam logic [1:0] S_DONE    = 2'(ST_DONE);
    localparam logic [1:0] S_TIMEOUT = 2'(ST_TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_run;
    logic              start_acc;
    logic              mbox_hit;
    logic              limit_hit;
    logic              cnt_en;
    logic [DATA_W-1:0] mbox_val;

    // The memory mux select is decoded straight from the state register, so ownership
    // flips on the same cycle the state does, with no turnaround cycle.
    assign in_run    = (state == S_RUN);
    assign start_acc = start && !in_run;
    assign mbox_hit  = in_run && cpu_we && (cpu_waddr == ADDR_WIDTH'(MBOX_ADDR));
    assign mbox_val  = cpu_wdata & DATA_W'(mode_mask(cpu_mode));

    // Next-state selection; a mailbox hit beats a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (mbox_hit)       state_nxt = S_DONE;
                else if (limit_hit) state_nxt = S_TIMEOUT;
            end
            default: begin
                if (start)      state_nxt = S_RUN;
                else if (clear) state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Capture the mailbox value; a new run starts from a clean result.
    always_ff @(posedge clk) begin
        if (rst || start_acc) result <= '0;
        else if (mbox_hit)    result <= mbox_val;
    end

    // Flag host writes attempted while the CPU owns d_mem; held until the next run starts.
    always_ff @(posedge clk) begin
        if (rst || start_acc)      host_err <= 1'b0;
        else if (in_run && host_we) host_err <= 1'b1;
    end

    // Count only cycles that are followed by another RUN cycle, so the final count
    // equals the index of the last cycle the CPU executed.
    assign cnt_en = in_run && (state_nxt == S_RUN);

    cpu_run_ctrl_cnt #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .en        (cnt_en),
        .cnt       (cycles),
        .limit_hit (limit_hit)
    );

    // d_mem ownership: the CPU in RUN, otherwise the host; host stores never leak into a run.
    assign mem_we    = in_run ? cpu_we    : host_we;
    assign mem_mode  = in_run ? cpu_mode  : host_mode;
    assign mem_waddr = in_run ? cpu_waddr : host_waddr;
    assign mem_raddr = in_run ? cpu_raddr : host_raddr;
    assign mem_wdata = in_run ? cpu_wdata : host_wdata;
    assign host_rdata = mem_rdata;

    assign cpu_n_rst = in_run;
    assign busy      = in_run;
    assign done      = (state == S_DONE);
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    assign timeout   = (state == S_TIMEOUT);
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Purpose: directed table-driven bench for cpu_run_ctrl with a byte-addressed d_mem model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: not applicable.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic        host_we;
    logic [1:0]  host_mode;
    logic [7:0]  host_waddr;
    logic [7:0]  host_raddr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        cpu_we;
    logic [1:0]  cpu_mode;
    logic [7:0]  cpu_waddr;
    logic [7:0]  cpu_raddr;
    logic [31:0] cpu_wdata;
    logic        cpu_n_rst;
    logic        mem_we;
    logic [1:0]  mem_mode;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        host_err;
    logic [31:0] result;
    logic [15:0] cycles;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_W     (32),
        .MBOX_ADDR  (8),
        .MAX_CYCLES (200),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .host_we    (host_we),
        .host_mode  (host_mode),
        .host_waddr (host_waddr),
        .host_raddr (host_raddr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .cpu_we     (cpu_we),
        .cpu_mode   (cpu_mode),
        .cpu_waddr  (cpu_waddr),
        .cpu_raddr  (cpu_raddr),
        .cpu_wdata  (cpu_wdata),
        .cpu_n_rst  (cpu_n_rst),
        .mem_we     (mem_we),
        .mem_mode   (mem_mode),
        .mem_waddr  (mem_waddr),
        .mem_raddr  (mem_raddr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .host_err   (host_err),
        .result     (result),
        .cycles     (cycles)
    );

    // Byte-addressed little-endian d_mem model.
    logic [7:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata[7:0];
            if (mem_mode != 2'b00) mem[mem_waddr + 8'd1] <= mem_wdata[15:8];
            if (mem_mode[1]) begin
                mem[mem_waddr + 8'd2] <= mem_wdata[23:16];
                mem[mem_waddr + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    assign mem_rdata = {mem[mem_raddr + 8'd3], mem[mem_raddr + 8'd2],
                        mem[mem_raddr + 8'd1], mem[mem_raddr]};

    typedef struct {
        logic        start;
        logic        clear;
        logic        cwe;
        logic [7:0]  caddr;
        logic [1:0]  cmode;
        logic [31:0] cwdata;
        logic        busy;
        logic        done;
        logic [31:0] result;
        logic [15:0] cycles;
    } vec_t;

    vec_t tv [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [31:0] d);
        host_raddr = a;
        #1;
        d = host_rdata;
    endtask

    task automatic cpu_store(input logic [7:0] a, input logic [1:0] m, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_waddr = a;
        cpu_mode  = m;
        cpu_wdata = d;
        tick();
        cpu_we    = 1'b0;
    endtask

    logic [31:0] rd;
    int          n;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        host_we = 1'b0; host_mode = 2'b10; host_waddr = 8'h00; host_raddr = 8'h00; host_wdata = 32'h0;
        cpu_we = 1'b0; cpu_mode = 2'b10; cpu_waddr = 8'h00; cpu_raddr = 8'h00; cpu_wdata = 32'h0;

        // Directed vectors: inputs for one cycle, expected status after the following edge.
        //          start clear cwe  caddr  cmode  cwdata         busy  done  result         cycles
        tv[0]  = '{1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         16'd0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 8'd0,  2'b00, 32'h0,         1'b1, 1'b0, 32'h0,         16'd0};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 8'd8,  2'b00, 32'h1234_56AB, 1'b0, 1'b1, 32'h0000_00AB, 16'd0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 8'd0,  2'b00, 32'h0,         1'b1, 1'b0, 32'h0,         16'd0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 8'd8,  2'b01, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_BEEF, 16'd0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 8'd0,  2'b00, 32'h0,         1'b0, 1'b0, 32'h0000_BEEF, 16'd0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 8'd0,  2'b00, 32'h0,         1'b0, 1'b0, 32'h0000_BEEF, 16'd0};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 8'd0,  2'b00, 32'h0,         1'b1, 1'b0, 32'h0,         16'd0};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 8'd12, 2'b10, 32'h1122_3344, 1'b1, 1'b0, 32'h0,         16'd1};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 8'd0,  2'b00, 32'h0,         1'b1, 1'b0, 32'h0,         16'd2};
        tv[10] = '{1'b0, 1'b1, 1'b0, 8'd0,  2'b00, 32'h0,         1'b1, 1'b0, 32'h0,         16'd3};
        tv[11] = '{1'b0, 1'b0, 1'b0, 8'd8,  2'b10, 32'h0000_0099, 1'b1, 1'b0, 32'h0,         16'd4};
        tv[12] = '{1'b0, 1'b0, 1'b1, 8'd8,  2'b10, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 16'd4};
        tv[13] = '{1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 16'd4};
        tv[14] = '{1'b1, 1'b0, 1'b0, 8'd0,  2'b00, 32'h0,         1'b1, 1'b0, 32'h0,         16'd0};
        tv[15] = '{1'b0, 1'b0, 1'b1, 8'd8,  2'b11, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 16'd0};

        // Reset state.
        repeat (2) tick();
        check("rst busy",      32'(busy),      32'd0);
        check("rst done",      32'(done),      32'd0);
        check("rst timeout",   32'(timeout),   32'd0);
        check("rst host_err",  32'(host_err),  32'd0);
        check("rst cpu_n_rst", 32'(cpu_n_rst), 32'd0);
        check("rst result",    result,         32'd0);
        check("rst cycles",    32'(cycles),    32'd0);
        rst = 1'b0;

        // Host word write of 0 to addr 8 while idle; the host drives d_mem.
        host_we = 1'b1; host_waddr = 8'd8; host_mode = 2'b10; host_wdata = 32'h0;
        #1;
        check("idle mem_we follows host",    32'(mem_we),    32'd1);
        check("idle mem_waddr follows host", 32'(mem_waddr), 32'd8);
        tick();
        host_we = 1'b0;
        check("host write cpu_n_rst", 32'(cpu_n_rst), 32'd0);
        host_read(8'd8, rd);
        check("host readback addr8", rd, 32'h0);

        // Table-driven run/mailbox/start/clear sequence.
        for (int i = 0; i < 16; i++) begin
            start = tv[i].start; clear = tv[i].clear;
            cpu_we = tv[i].cwe; cpu_waddr = tv[i].caddr; cpu_mode = tv[i].cmode; cpu_wdata = tv[i].cwdata;
            tick();
            start = 1'b0; clear = 1'b0; cpu_we = 1'b0;
            check($sformatf("v%0d busy", i),      32'(busy),      32'(tv[i].busy));
            check($sformatf("v%0d cpu_n_rst", i), 32'(cpu_n_rst), 32'(tv[i].busy));
            check($sformatf("v%0d done", i),      32'(done),      32'(tv[i].done));
            check($sformatf("v%0d timeout", i),   32'(timeout),   32'd0);
            check($sformatf("v%0d result", i),    result,         tv[i].result);
            check($sformatf("v%0d cycles", i),    32'(cycles),    32'(tv[i].cycles));
        end
        host_read(8'd8, rd);
        check("mailbox word in d_mem", rd, 32'h0000_0001);
        host_read(8'd12, rd);
        check("cpu store addr12 in d_mem", rd, 32'h1122_3344);

        // Host write attempted during RUN is blocked and flagged.
        start = 1'b1; tick(); start = 1'b0;
        check("run2 busy", 32'(busy), 32'd1);
        host_we = 1'b1; host_waddr = 8'd16; host_wdata = 32'h0000_0055; host_mode = 2'b10;
        #1;
        check("run mem_we follows cpu", 32'(mem_we), 32'd0);
        tick();
        host_we = 1'b0;
        check("host_err set", 32'(host_err), 32'd1);
        cpu_store(8'd8, 2'b10, 32'h0000_0007);
        check("run2 done",            32'(done),     32'd1);
        check("run2 host_err sticky", 32'(host_err), 32'd1);
        check("run2 cycles",          32'(cycles),   32'd1);
        host_read(8'd16, rd);
        check("blocked host write addr16", rd, 32'hFFFF_FFFF);
        start = 1'b1; tick(); start = 1'b0;
        check("restart host_err clear", 32'(host_err), 32'd0);
        check("restart cycles",         32'(cycles),   32'd0);
        check("restart done",           32'(done),     32'd0);

        // Reset mid-RUN: CPU held again next cycle, status cleared, d_mem kept.
        tick(); tick();
        host_we = 1'b1; host_waddr = 8'd16; tick(); host_we = 1'b0;
        check("pre-rst cycles",   32'(cycles),   32'd3);
        check("pre-rst host_err", 32'(host_err), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst busy",      32'(busy),      32'd0);
        check("midrst cpu_n_rst", 32'(cpu_n_rst), 32'd0);
        check("midrst done",      32'(done),      32'd0);
        check("midrst timeout",   32'(timeout),   32'd0);
        check("midrst host_err",  32'(host_err),  32'd0);
        check("midrst result",    result,         32'd0);
        check("midrst cycles",    32'(cycles),    32'd0);
        host_read(8'd8, rd);
        check("midrst d_mem kept", rd, 32'h0000_0007);

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
        // Program that never hits the mailbox: exactly MAX_CYCLES RUN cycles.
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("wd run cycles",  32'(n),         32'd200);
        check("wd timeout",     32'(timeout),   32'd1);
        check("wd done",        32'(done),      32'd0);
        check("wd cycles",      32'(cycles),    32'd199);
        check("wd cpu_n_rst",   32'(cpu_n_rst), 32'd0);
        check("wd result",      result,         32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("wd clear timeout", 32'(timeout), 32'd0);
        check("wd clear busy",    32'(busy),    32'd0);
`else
        // Without the watchdog a looping program keeps running.
        start = 1'b1; tick(); start = 1'b0;
        repeat (1000) tick();
        check("nowd busy",    32'(busy),    32'd1);
        check("nowd timeout", 32'(timeout), 32'd0);
        check("nowd cycles",  32'(cycles),  32'd1000);
        cpu_store(8'd8, 2'b10, 32'h0000_0003);
        check("nowd done", 32'(done), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
`endif

        // Mailbox store on the watchdog-expiry cycle: DONE wins.
        start = 1'b1; tick(); start = 1'b0;
        repeat (199) tick();
        check("exp busy",   32'(busy),   32'd1);
        check("exp cycles", 32'(cycles), 32'd199);
        cpu_store(8'd8, 2'b10, 32'h0000_005A);
        check("exp done",    32'(done),    32'd1);
        check("exp timeout", 32'(timeout), 32'd0);
        check("exp result",  result,       32'h0000_005A);
        check("exp hold",    32'(cycles),  32'd199);
        tick();
        check("exp done level", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
